// File: rtl/moving_average_ctrl_pkg.sv
// moving_average_ctrl_pkg: shared parameters, FSM state type and window check
// for the moving-average controller and the blocks around it.
package moving_average_ctrl_pkg;
    localparam int SIZE_WINDOW     = 7;
    localparam int SIZE_MAX_WINDOW = 64;
    localparam int CNT_W           = SIZE_WINDOW + 1;
    localparam int PIPE_LATENCY    = 6;
    localparam int FLUSH_CYCLES    = 2;

    typedef enum logic [1:0] {IDLE, FLUSH, FILL, RUN} ma_ctrl_state_t;

    // A window is usable when it is a non-zero power of two within 1..64
    // and not deeper than the datapath supports.
    function automatic logic is_valid_window(input logic [SIZE_WINDOW-1:0] w);
        int v;
        v = int'(w);
        return (v != 0) && ((v & (v - 1)) == 0) && (v <= 64) && (v <= SIZE_MAX_WINDOW);
    endfunction
endpackage

// File: rtl/moving_average_ctrl_if.sv
// moving_average_ctrl_if: configuration handshake, pause and datapath-control
// signals of the moving-average controller.
//   master: drives cfg_valid, cfg_window, pause; observes everything else
//   slave : the controller, drives cfg_ready, cfg_error, ma_*, out_valid, state
interface moving_average_ctrl_if;
    import moving_average_ctrl_pkg::*;
    logic                   cfg_valid;
    logic [SIZE_WINDOW-1:0] cfg_window;
    logic                   cfg_ready;
    logic                   cfg_error;
    logic                   pause;
    logic                   ma_reset_n;
    logic [SIZE_WINDOW-1:0] ma_window_set;
    logic                   ma_enable;
    logic                   out_valid;
    ma_ctrl_state_t         state;

    modport master (
        output cfg_valid, cfg_window, pause,
        input  cfg_ready, cfg_error, ma_reset_n, ma_window_set, ma_enable, out_valid, state
    );
    modport slave (
        input  cfg_valid, cfg_window, pause,
        output cfg_ready, cfg_error, ma_reset_n, ma_window_set, ma_enable, out_valid, state
    );
endinterface

// File: rtl/moving_average_ctrl.sv
// moving_average_ctrl: sequences flush, fill and run of a moving-average datapath.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of moving_average_ctrl_if (window request handshake,
//           pause, datapath reset/window/enable, out_valid, current state)
module moving_average_ctrl
    import moving_average_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    moving_average_ctrl_if.slave bus
);
    ma_ctrl_state_t         state, state_next;
    logic [CNT_W-1:0]       fill_cnt, fill_last;
    logic [SIZE_WINDOW-1:0] window_set;
    logic                   cfg_ready, cfg_error, ma_reset_n, ma_enable, out_valid;
    logic                   xfer, win_ok;

    assign xfer      = bus.cfg_valid && cfg_ready;
    assign win_ok    = is_valid_window(bus.cfg_window);
    assign fill_last = {1'b0, window_set} + CNT_W'(PIPE_LATENCY - 1);

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_next;

    always_comb begin
        state_next = state;
        if (xfer && win_ok)                                           state_next = FLUSH;
        else if (state == FLUSH && fill_cnt == CNT_W'(FLUSH_CYCLES - 1)) state_next = FILL;
        else if (state == FILL && fill_cnt == fill_last)              state_next = RUN;
    end

    // Counts cycles spent in FLUSH and in FILL; restarts on every state change.
    always_ff @(posedge clk or negedge reset)
        if (!reset) fill_cnt <= '0;
        else        fill_cnt <= (state_next != state || !(state == FLUSH || state == FILL)) ? '0 : fill_cnt + CNT_W'(1);

    // Outputs are registered from the next state so they line up with the
    // state register rather than trailing it by a cycle.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cfg_ready  <= 1'b1;
            cfg_error  <= 1'b0;
            ma_reset_n <= 1'b0;
            window_set <= SIZE_WINDOW'(1);
            ma_enable  <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            cfg_ready  <= state_next == IDLE || state_next == RUN;
            cfg_error  <= xfer && !win_ok;
            ma_reset_n <= state_next == FILL || state_next == RUN;
            window_set <= (xfer && win_ok) ? bus.cfg_window : window_set;
            ma_enable  <= state_next == RUN && !bus.pause;
            out_valid  <= state_next == RUN && !bus.pause;
        end

    assign bus.state         = state;
    assign bus.cfg_ready     = cfg_ready;
    assign bus.cfg_error     = cfg_error;
    assign bus.ma_reset_n    = ma_reset_n;
    assign bus.ma_window_set = window_set;
    assign bus.ma_enable     = ma_enable;
    assign bus.out_valid     = out_valid;
endmodule
